// File: rtl/hora_alarma_ctrl.sv
// Hour / alarm-hour producer for the 7-seg hour display: set-mode FSM, alarm arm and buzzer.
// Optional feature: define SNOOZE_EN to build the snooze counter (BTN_INC while ringing in RUN).
module hora_alarma_ctrl #(
    parameter int H_MAX       = 24,
    parameter int BUZZ_CICLOS = 1000
`ifdef SNOOZE_EN
   ,parameter int SNOOZE_CICLOS = 500
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK_HR,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    input  logic       BTN_ALM,
    output logic [5:0] HORA,
    output logic [5:0] AHORA,
    output logic       ALARM,
    output logic       ALARM_ON,
    output logic       BUZZ,
    output logic       SET_ACT
);

    typedef enum logic [1:0] {RUN, SET_HORA, SET_ALARMA} estado_t;

    localparam int BW = (BUZZ_CICLOS > 1) ? $clog2(BUZZ_CICLOS) : 1;

    estado_t       estado, estado_sig;
    logic          mode_q, inc_q, alm_q;
    logic          mode_e, inc_e, alm_e;
    logic [5:0]    hora, ahora;
    logic          alarm_on, buzz;
    logic [BW-1:0] cnt_buzz;
    logic          ring_start, snooze_go, snooze_fin;

    function automatic logic [5:0] inc_hora(input logic [5:0] x);
        return (x == 6'(H_MAX - 1)) ? '0 : x + 6'd1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= 1'b0;
            inc_q  <= 1'b0;
            alm_q  <= 1'b0;
        end else begin
            mode_q <= BTN_MODE;
            inc_q  <= BTN_INC;
            alm_q  <= BTN_ALM;
        end
    end

    assign mode_e = BTN_MODE & ~mode_q;
    assign inc_e  = BTN_INC  & ~inc_q;
    assign alm_e  = BTN_ALM  & ~alm_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) estado <= RUN;
        else     estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        if (mode_e) begin
            unique case (estado)
                RUN:        estado_sig = SET_HORA;
                SET_HORA:   estado_sig = SET_ALARMA;
                SET_ALARMA: estado_sig = RUN;
                default:    estado_sig = RUN;
            endcase
        end
    end

    always_comb begin
        ALARM   = (estado == SET_ALARMA);
        SET_ACT = (estado != RUN);
    end

    // Ringing only from the hour tick while staying in RUN; a same-cycle disarm suppresses it.
    assign ring_start = (estado == RUN) && !mode_e && alarm_on && !(alm_e && !buzz)
                        && TICK_HR && (inc_hora(hora) == ahora);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hora     <= '0;
            ahora    <= '0;
            alarm_on <= 1'b0;
        end else begin
            if (estado == SET_HORA) begin
                if (inc_e && !mode_e) hora <= inc_hora(hora);
            end else if (TICK_HR) begin
                hora <= inc_hora(hora);
            end
            if (estado == SET_ALARMA && inc_e && !mode_e) ahora <= inc_hora(ahora);
            if (alm_e && !buzz) alarm_on <= ~alarm_on;
        end
    end

`ifdef SNOOZE_EN
    localparam int SW = (SNOOZE_CICLOS > 1) ? $clog2(SNOOZE_CICLOS) : 1;
    logic          snoozing;
    logic [SW-1:0] cnt_snz;

    assign snooze_go  = (estado == RUN) && buzz && inc_e && !mode_e;
    assign snooze_fin = snoozing && (cnt_snz == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            snoozing <= 1'b0;
            cnt_snz  <= '0;
        end else if (ring_start || mode_e || alm_e) begin
            snoozing <= 1'b0;
        end else if (snooze_go) begin
            snoozing <= 1'b1;
            cnt_snz  <= SW'(SNOOZE_CICLOS - 1);
        end else if (snoozing) begin
            if (cnt_snz == '0) snoozing <= 1'b0;
            else               cnt_snz  <= cnt_snz - 1'b1;
        end
    end
`else
    assign snooze_go  = 1'b0;
    assign snooze_fin = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buzz     <= 1'b0;
            cnt_buzz <= '0;
        end else if (ring_start) begin
            buzz     <= 1'b1;
            cnt_buzz <= BW'(BUZZ_CICLOS - 1);
        end else if (mode_e || alm_e) begin
            buzz <= 1'b0;
        end else if (snooze_fin) begin
            buzz     <= 1'b1;
            cnt_buzz <= BW'(BUZZ_CICLOS - 1);
        end else if (snooze_go) begin
            buzz <= 1'b0;
        end else if (buzz) begin
            if (cnt_buzz == '0) buzz     <= 1'b0;
            else                cnt_buzz <= cnt_buzz - 1'b1;
        end
    end

    assign HORA     = hora;
    assign AHORA    = ahora;
    assign ALARM_ON = alarm_on;
    assign BUZZ     = buzz;

endmodule
